// File: rtl/count_sched.sv
// Two-requester scheduler that lends one external counter to a requester
// for a timed interval of term+2 granted cycles, with round-robin arbitration.
module count_sched #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] len1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic             cnt_enable,
   output logic             cnt_clear,
   input  logic [WIDTH-1:0] cnt_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             owner;
   logic             last;
   logic             pick;
   logic [WIDTH-1:0] term;
   logic [1:0]       owner_onehot;

   // Contested requests go to whoever was not served last.
   always_comb begin
      pick = ~last;
      case (req)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         default: pick = ~last;
      endcase
   end

   assign owner_onehot = owner ? 2'b10 : 2'b01;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Interval length is captured at grant so later len changes cannot disturb it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         term  <= '0;
         owner <= 1'b0;
         last  <= 1'b1;
      end else begin
         if (state == IDLE && req != 2'b00) begin
            term  <= pick ? len1 : len0;
            owner <= pick;
         end
         if (state == DONE) begin
            last <= owner;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req != 2'b00) state_next = CLEAR;
         CLEAR:   state_next = RUN;
         RUN:     if (cnt_out == term) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      gnt        = 2'b00;
      done       = 2'b00;
      cnt_enable = 1'b0;
      cnt_clear  = 1'b0;
      busy       = (state != IDLE);
      case (state)
         CLEAR: begin
            gnt       = owner_onehot;
            cnt_clear = 1'b1;
         end
         RUN: begin
            gnt        = owner_onehot;
            cnt_enable = (cnt_out != term);
         end
         DONE:    done = owner_onehot;
         default: ;
      endcase
   end

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter WIDTH, default 4, sets the bit width of the controlled counter and of the interval lengths.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clock.
REQ-004 req  input  2  request lines; req[i] high = requester i wants one timed interval.
REQ-005 len0  input  WIDTH  terminal count for requester 0, sampled at grant.
REQ-006 len1  input  WIDTH  terminal count for requester 1, sampled at grant.
REQ-007 gnt  output  2  one-hot grant; gnt[i] high while requester i owns the counter.
REQ-008 done  output  2  one-cycle pulse on done[i] when requester i's interval completes.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 cnt_enable  output  1  drives the external counter's enable input.
REQ-011 cnt_clear  output  1  drives the external counter's active-high synchronous clear input.
REQ-012 cnt_out  input  WIDTH  current value of the external counter.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, CLEAR, RUN, DONE.
REQ-014 In IDLE with req==00, the FSM SHALL remain in IDLE.
REQ-015 In IDLE with exactly one req bit high, the FSM SHALL grant that requester, latch its len into an internal term register, record the owner, and go to CLEAR.
REQ-016 In IDLE with req==11, the FSM SHALL grant the requester that was not granted last (round-robin).
REQ-017 The last-served pointer SHALL update in DONE to the owner.
REQ-018 CLEAR SHALL last exactly one cycle with cnt_clear=1 and cnt_enable=0, then go to RUN.
REQ-019 In RUN, cnt_enable SHALL equal (cnt_out != term), decoded combinationally, and cnt_clear SHALL be 0.
REQ-020 In RUN, when cnt_out==term, the FSM SHALL go to DONE on that edge.
REQ-021 The counter SHALL therefore stop at term and never wrap; term=2^WIDTH-1 is legal.
REQ-022 DONE SHALL last one cycle with done[owner]=1, gnt=00, cnt_enable=0, then go to IDLE.
REQ-023 gnt[owner] SHALL be high in CLEAR and RUN only, for exactly term+2 cycles.
REQ-024 The done[owner] pulse SHALL begin term+2 cycles after the edge that issued the grant.
REQ-025 len0/len1 changes after grant SHALL not affect the active interval.
REQ-026 Deasserting req after grant SHALL not abort the interval; it runs to DONE.
REQ-027 A request still high in the IDLE cycle following DONE SHALL be arbitrated then; back-to-back service costs exactly one IDLE cycle.
REQ-028 term=0 SHALL complete after one RUN cycle with no counter increment.
REQ-029 gnt and done SHALL each be one-hot or zero at all times.

Reset
REQ-030 While reset is low, state SHALL be IDLE, with gnt=00, done=00, busy=0, cnt_enable=0, cnt_clear=0, and term=0.
REQ-031 Reset SHALL set the last-served pointer to requester 1, so requester 0 wins the first contested arbitration.
REQ-032 Reset asserted mid-interval SHALL abandon the interval without a done pulse; the next grant's CLEAR re-initialises the counter.

Verification
REQ-033 Single request: req=01, len0=3 -> gnt=01 for 5 cycles, cnt_out steps 0,1,2,3 and holds, one-cycle done=01, busy low afterwards.
REQ-034 Contention: reset, then req=11, len0=2, len1=1 -> requester 0 served first (gnt=01 for 4 cycles), one IDLE cycle, then gnt=10 for 3 cycles, then done=10.
REQ-035 Fairness: req held at 11 for four intervals -> grants alternate 01,10,01,10.
REQ-036 Zero length: req=10, len1=0 -> gnt=10 for 2 cycles, cnt_enable never high, done=10.
REQ-037 Max length plus operand change: len0=15, with len0 changed to 2 during RUN -> counter reaches 15, no wrap to 0, done after 17 granted cycles.
REQ-038 Async reset: reset driven low mid-RUN between clock edges -> gnt, busy and cnt_enable drop immediately, no done pulse, and the next request is served normally.
